// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, repeat_n times.
// Optional one-cycle gap between repetitions when SEQ_PATTERN_TX_GAP_EN is defined.
module seq_pattern_tx #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             ready,
    output logic             x,
    output logic             valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

`ifdef SEQ_PATTERN_TX_GAP_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
`endif

    state_t           r_state, w_state_d;
    logic [PAT_W-1:0] r_pat, w_pat_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [IDX_W-1:0] r_idx, w_idx_d;
    logic [IDX_W-1:0] w_idx_m1;
    logic             r_x, w_x_d;
    logic             r_valid, w_valid_d;
    logic             r_frame_start, w_frame_start_d;
    logic             r_done, w_done_d;
    logic             r_ready, w_ready_d;

    assign w_idx_m1 = r_idx - IDX_W'(1);

    // Outputs are registered, so the next-state logic also computes next-cycle outputs.
    always_comb begin
        w_state_d       = r_state;
        w_pat_d         = r_pat;
        w_cnt_d         = r_cnt;
        w_idx_d         = r_idx;
        w_x_d           = 1'b0;
        w_valid_d       = 1'b0;
        w_frame_start_d = 1'b0;
        w_done_d        = 1'b0;
        w_ready_d       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_d = 1'b1;
                if (start) begin
                    w_pat_d   = pattern;
                    w_cnt_d   = repeat_n;
                    w_ready_d = 1'b0;
                    if (repeat_n != '0) begin
                        w_state_d       = SHIFT;
                        w_idx_d         = IDX_MAX;
                        w_x_d           = pattern[PAT_W-1];
                        w_valid_d       = 1'b1;
                        w_frame_start_d = 1'b1;
                    end else begin
                        w_state_d = FIN;
                        w_done_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_state_d = FIN;
                    w_done_d  = 1'b1;
                end else if (r_idx == '0) begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_d = FIN;
                        w_done_d  = 1'b1;
                    end else begin
`ifdef SEQ_PATTERN_TX_GAP_EN
                        w_state_d = GAP;
`else
                        w_idx_d         = IDX_MAX;
                        w_x_d           = r_pat[PAT_W-1];
                        w_valid_d       = 1'b1;
                        w_frame_start_d = 1'b1;
`endif
                    end
                end else begin
                    w_idx_d   = w_idx_m1;
                    w_x_d     = r_pat[w_idx_m1];
                    w_valid_d = 1'b1;
                end
            end
`ifdef SEQ_PATTERN_TX_GAP_EN
            GAP: begin
                if (abort) begin
                    w_state_d = FIN;
                    w_done_d  = 1'b1;
                end else begin
                    w_state_d       = SHIFT;
                    w_idx_d         = IDX_MAX;
                    w_x_d           = r_pat[PAT_W-1];
                    w_valid_d       = 1'b1;
                    w_frame_start_d = 1'b1;
                end
            end
`endif
            FIN: begin
                w_state_d = IDLE;
                w_ready_d = 1'b1;
            end
            default: begin
                w_state_d = IDLE;
                w_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pat         <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_x           <= 1'b0;
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
            r_ready       <= 1'b1;
        end else begin
            r_state       <= w_state_d;
            r_pat         <= w_pat_d;
            r_cnt         <= w_cnt_d;
            r_idx         <= w_idx_d;
            r_x           <= w_x_d;
            r_valid       <= w_valid_d;
            r_frame_start <= w_frame_start_d;
            r_done        <= w_done_d;
            r_ready       <= w_ready_d;
        end
    end

    assign ready       = r_ready;
    assign x           = r_x;
    assign valid       = r_valid;
    assign frame_start = r_frame_start;
    assign done        = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx (PAT_W=4, CNT_W=8).
// Gap scenario runs only when SEQ_PATTERN_TX_GAP_EN is defined.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] repeat_n;
    logic       abort;
    logic       ready;
    logic       x;
    logic       valid;
    logic       frame_start;
    logic       done;

    int checks;
    int failures;

    seq_pattern_tx #(
        .PAT_W(4),
        .CNT_W(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern     (pattern),
        .repeat_n    (repeat_n),
        .abort       (abort),
        .ready       (ready),
        .x           (x),
        .valid       (valid),
        .frame_start (frame_start),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ready, x, valid, frame_start, done} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_state: got %b want 10000", {ready, x, valid, frame_start, done});
        end
    endtask

    task automatic test_basic();
        logic [3:0] pat;
        pat = 4'b1011;
        pattern = pat;
        repeat_n = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            checks++;
            if ({valid, x, frame_start, ready, done} !== {1'b1, pat[3-i], (i == 0), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL basic_bit%0d: got v/x/fs/rdy/done=%b want %b", i,
                         {valid, x, frame_start, ready, done}, {1'b1, pat[3-i], (i == 0), 2'b00});
            end
        end
        tick();
        checks++;
        if ({valid, x, ready, done} !== 4'b0001) begin
            failures++;
            $display("FAIL basic_done: got v/x/rdy/done=%b want 0001", {valid, x, ready, done});
        end
        tick();
        checks++;
        if ({ready, done} !== 2'b10) begin
            failures++;
            $display("FAIL basic_ready: got rdy/done=%b want 10", {ready, done});
        end
    endtask

    task automatic test_repeats();
        logic [11:0] exp_stream;
        logic [3:0]  shreg;
        int          hits;
        exp_stream = 12'b1011_1011_1011;
        shreg = 4'b0000;
        hits = 0;
        pattern = 4'b1011;
        repeat_n = 8'd3;
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            start = 1'b0;
            pattern = 4'b0000;
            repeat_n = 8'd9;
            checks++;
            if ({valid, x, frame_start} !== {1'b1, exp_stream[11-i], ((i % 4) == 0)}) begin
                failures++;
                $display("FAIL repeats_bit%0d: got v/x/fs=%b want %b", i, {valid, x, frame_start},
                         {1'b1, exp_stream[11-i], ((i % 4) == 0)});
            end
            if (valid) begin
                shreg = {shreg[2:0], x};
                if (shreg == 4'b1011) hits++;
            end
        end
        tick();
        checks++;
        if ({valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL repeats_done: got v/done=%b want 01", {valid, done});
        end
        checks++;
        if (hits != 3) begin
            failures++;
            $display("FAIL repeats_detect: got %0d detections want 3", hits);
        end
        tick();
    endtask

`ifdef SEQ_PATTERN_TX_GAP_EN
    task automatic test_gap();
        // cycles 1..10: 1011, gap, 1011, done
        logic [9:0] exp_v;
        logic [9:0] exp_x;
        logic [9:0] exp_d;
        exp_v = 10'b1111011110;
        exp_x = 10'b1011010110;
        exp_d = 10'b0000000001;
        pattern = 4'b1011;
        repeat_n = 8'd2;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
            checks++;
            if ({valid, x, done} !== {exp_v[9-i], exp_x[9-i], exp_d[9-i]}) begin
                failures++;
                $display("FAIL gap_cycle%0d: got v/x/done=%b want %b", i + 1, {valid, x, done},
                         {exp_v[9-i], exp_x[9-i], exp_d[9-i]});
            end
        end
        tick();
    endtask
`endif

    task automatic test_zero_count();
        pattern = 4'b1111;
        repeat_n = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({valid, x, ready, done} !== 4'b0001) begin
            failures++;
            $display("FAIL zero_done: got v/x/rdy/done=%b want 0001", {valid, x, ready, done});
        end
        tick();
        checks++;
        if ({valid, ready, done} !== 3'b010) begin
            failures++;
            $display("FAIL zero_idle: got v/rdy/done=%b want 010", {valid, ready, done});
        end
    endtask

    task automatic test_ignored_start();
        // start held high: first 1011 (n=1), done, idle, then 0110 accepted
        logic [10:0] exp_v;
        logic [10:0] exp_x;
        logic [10:0] exp_r;
        logic [10:0] exp_d;
        exp_v = 11'b11110011110;
        exp_x = 11'b10110001100;
        exp_r = 11'b00000100000;
        exp_d = 11'b00001000001;
        pattern = 4'b1011;
        repeat_n = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 0) begin
                pattern = 4'b0110;
                repeat_n = 8'd3;
            end
            if (i == 4) repeat_n = 8'd1;
            if (i == 6) start = 1'b0;
            checks++;
            if ({valid, x, ready, done} !== {exp_v[10-i], exp_x[10-i], exp_r[10-i], exp_d[10-i]}) begin
                failures++;
                $display("FAIL ignored_start_cycle%0d: got v/x/rdy/done=%b want %b", i + 1,
                         {valid, x, ready, done},
                         {exp_v[10-i], exp_x[10-i], exp_r[10-i], exp_d[10-i]});
            end
        end
        tick();
    endtask

    task automatic test_abort();
        pattern = 4'b1011;
        repeat_n = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({valid, x} !== 2'b11) begin
            failures++;
            $display("FAIL abort_bit1: got v/x=%b want 11", {valid, x});
        end
        tick();
        abort = 1'b1;
        checks++;
        if ({valid, x} !== 2'b10) begin
            failures++;
            $display("FAIL abort_bit2: got v/x=%b want 10", {valid, x});
        end
        tick();
        abort = 1'b0;
        checks++;
        if ({valid, x, ready, done} !== 4'b0001) begin
            failures++;
            $display("FAIL abort_done: got v/x/rdy/done=%b want 0001", {valid, x, ready, done});
        end
        tick();
        checks++;
        if ({ready, done, valid} !== 3'b100) begin
            failures++;
            $display("FAIL abort_ready: got rdy/done/v=%b want 100", {ready, done, valid});
        end
        // abort alongside start in IDLE: start wins
        pattern = 4'b1101;
        repeat_n = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            checks++;
            if ({valid, x, done} !== ((i < 4) ? {1'b1, pattern[3-i], 1'b0} : 3'b001)) begin
                failures++;
                $display("FAIL start_abort_cycle%0d: got v/x/done=%b", i + 1, {valid, x, done});
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] pat;
        pattern = 4'b1011;
        repeat_n = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ready, valid, x, done, frame_start} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_mid_state: got rdy/v/x/done/fs=%b want 10000",
                     {ready, valid, x, done, frame_start});
        end
        pat = 4'b0110;
        pattern = pat;
        repeat_n = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            checks++;
            if ({valid, x} !== {1'b1, pat[3-i]}) begin
                failures++;
                $display("FAIL reset_mid_bit%0d: got v/x=%b want %b", i, {valid, x}, {1'b1, pat[3-i]});
            end
        end
        tick();
        checks++;
        if ({valid, done} !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_done: got v/done=%b want 01", {valid, done});
        end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        pattern = 4'b0000;
        repeat_n = 8'd0;
        abort = 1'b0;
        test_reset();
        test_basic();
        test_repeats();
`ifdef SEQ_PATTERN_TX_GAP_EN
        test_gap();
`endif
        test_zero_count();
        test_ignored_start();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
